// File: rtl/axis_fifo_stage.sv
// AXI4-Stream FIFO stage with a registered first-word-fall-through output.
// Optional packet mode (store-and-forward per packet): define AXIS_FIFO_PACKET_MODE_EN.
module axis_fifo_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] fill_nxt;
    logic [BW-1:0] s_beat;
    logic [BW-1:0] head_nxt;
    logic          full;
    logic          push;
    logic          pop;
    logic          load;
    logic          valid_nxt;

    // Wrap bit differs while the index bits match: every slot is occupied.
    assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign s_axis_tready = ~full & ~areset;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign load          = ~m_axis_tvalid | m_axis_tready;
    assign s_beat        = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rd_ptr_nxt = rd_ptr + PW'(pop);
        fill_nxt   = fill_level + PW'(push) - PW'(pop);
        // When the next head is the beat being written this edge, take it from the input.
        head_nxt   = (rd_ptr_nxt == wr_ptr) ? s_beat : mem[rd_ptr_nxt[AW-1:0]];
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [PW-1:0] pkt_cnt;
    logic [PW-1:0] pkt_nxt;
    logic          drain;
    logic          drain_nxt;

    // An oversize packet fills the FIFO with no tlast; cut through until its tlast leaves.
    always_comb begin
        pkt_nxt   = pkt_cnt + PW'(push & s_axis_tlast) - PW'(pop & m_axis_tlast);
        drain_nxt = (drain & ~(pop & m_axis_tlast)) |
                    ((fill_nxt == PW'(DEPTH)) && (pkt_nxt == '0));
        valid_nxt = (fill_nxt != '0) && ((pkt_nxt != '0) || drain_nxt);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt <= '0;
            drain   <= 1'b0;
        end else begin
            pkt_cnt <= pkt_nxt;
            drain   <= drain_nxt;
        end
    end
`else
    assign valid_nxt = (fill_nxt != '0);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr_nxt;
            fill_level <= fill_nxt;
            // A presented beat is held until accepted; reload only when the slot frees up.
            if (load) begin
                m_axis_tvalid <= valid_nxt;
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= head_nxt;
            end
        end
    end

    // NOTE: storage is not reset; pointers define which entries are meaningful.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_beat;
        end
    end

endmodule

// File: tb/tb_axis_fifo_stage.sv
// Randomized self-checking bench for axis_fifo_stage against a queue-based reference model.
// Define AXIS_FIFO_PACKET_MODE_EN for both files to exercise packet mode.
module tb_axis_fifo_stage;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int KW    = DW / 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [PW-1:0] fill_level;

    always #5 aclk = ~aclk;

    axis_fifo_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fill_level    (fill_level)
    );

    // Reference model: the ordered list of held beats plus the expected output valid.
    beat_t q[$];
    bit    exp_valid;
    bit    drain;
    bit    did_push;
    bit    did_pop;
    beat_t popped_beat;
    int    popped_n;
    int    checks;
    int    errors;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit q_has_last();
        foreach (q[i]) if (q[i].last) return 1'b1;
        return 1'b0;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.data = DW'($urandom);
        b.keep = KW'($urandom);
        b.last = ($urandom_range(0, 3) == 0);
        return b;
    endfunction

    // Drive one clock's inputs at a falling edge, advance one cycle, update the model, compare.
    task automatic cycle(input bit rst, input bit sv, input beat_t b, input bit mr);
        areset        = rst;
        s_axis_tvalid = sv;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        m_axis_tready = mr;
        did_push = !rst && sv && (q.size() < DEPTH);
        did_pop  = !rst && exp_valid && mr;
        @(negedge aclk);
        if (rst) begin
            q.delete();
            exp_valid = 1'b0;
            drain     = 1'b0;
        end else begin
            if (did_pop) begin
                popped_beat = q.pop_front();
                popped_n++;
                if (popped_beat.last) drain = 1'b0;
            end
            if (did_push) q.push_back(b);
`ifdef AXIS_FIFO_PACKET_MODE_EN
            if (q.size() == DEPTH && !q_has_last()) drain = 1'b1;
            exp_valid = (q.size() > 0) && ((exp_valid && !did_pop) || q_has_last() || drain);
`else
            exp_valid = (q.size() > 0);
`endif
        end
        check("s_tready", s_axis_tready, !rst && (q.size() < DEPTH));
        check("fill_level", fill_level, q.size());
        check("m_tvalid", m_axis_tvalid, exp_valid);
        if (exp_valid) check("m_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, q[0]);
        if (rst) check("reset_outputs", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    endtask

    initial begin
        beat_t b;
        int    idx;
        int    base;

        checks = 0; errors = 0; popped_n = 0;
        exp_valid = 1'b0; drain = 1'b0;
        areset = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        @(negedge aclk);

        // Reset held three cycles, then idle.
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);

        // Single beat appears on the output one cycle after the push.
        b = {1'b1, 4'hF, 32'hDEADBEEF};
        cycle(1'b0, 1'b1, b, 1'b1);
        check("single_tdata", m_axis_tdata, 32'hDEADBEEF);
        check("single_fill", fill_level, 1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("single_empty", fill_level, 0);

        // Source holds beats 0..19 until accepted; sink stalled for 20 cycles then drains.
        idx = 0;
        base = popped_n;
        for (int cyc = 0; cyc < 200 && (popped_n - base) < 20; cyc++) begin
            b = {(idx == 19), {KW{1'b1}}, DW'(idx)};
            cycle(1'b0, idx < 20, b, cyc >= 20);
            if (cyc == 19) check("t3_full_level", fill_level, DEPTH);
            if (did_push) idx++;
        end
        check("t3_beats_out", popped_n - base, 20);
        check("t3_last_data", popped_beat.data, 19);

        // Full FIFO with push and pop requested together: only the pop happens.
        for (int i = 0; i < 40 && q.size() < DEPTH; i++) cycle(1'b0, 1'b1, rand_beat(), 1'b0);
        cycle(1'b0, 1'b1, rand_beat(), 1'b1);
        check("t5_fill_after_pop", fill_level, DEPTH - 1);
        check("t5_tready_back", s_axis_tready, 1);
        repeat (DEPTH + 4) cycle(1'b0, 1'b0, '0, 1'b1);

        // Continuous push against a 2-low / 6-high ready pattern.
        for (int k = 0; k < 200; k++) cycle(1'b0, 1'b1, rand_beat(), (k % 8) >= 2);
        repeat (DEPTH + 4) cycle(1'b0, 1'b0, '0, 1'b1);

        // Fully random valid/ready traffic.
        for (int k = 0; k < 400; k++)
            cycle(1'b0, $urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 2) != 0);

        // Reset in the middle of a packet: held beats vanish, next beat out is new data.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, {1'b0, KW'($urandom), DW'(100 + k)}, 1'b0);
        cycle(1'b1, 1'b1, rand_beat(), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        b = {1'b1, {KW{1'b1}}, 32'hCAFE0001};
        cycle(1'b0, 1'b1, b, 1'b0);
        check("post_reset_beat", m_axis_tdata, 32'hCAFE0001);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Four-beat packet is held back until its tlast beat is stored.
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, {(k == 3), {KW{1'b1}}, DW'(200 + k)}, 1'b1);
        check("pkt4_released", m_axis_tvalid, 1);
        repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);
        // Oversize packet: output starts only once the FIFO is full.
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, {(k == 19), {KW{1'b1}}, DW'(300 + k)}, 1'b1);
        repeat (DEPTH + 8) cycle(1'b0, 1'b0, '0, 1'b1);
        check("pkt_oversize_drained", fill_level, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
